// File: rtl/ca_prng_line_gen_if.sv
// Control, pixel-query and status bundle between the video timing logic and the CA line generator.
// The timing side is the master; the generator is the slave.
interface ca_prng_line_gen_if #(
  parameter int unsigned XW = 10
);
  logic          i_mode;
  logic          i_frame_start;
  logic          i_line_start;
  logic          i_de;
  logic [XW-1:0] i_x;
  logic          i_clr_underrun;
  logic [7:0]    o_pix;
  logic          o_ready;
  logic          o_underrun;
  logic [15:0]   o_gen;

  modport master (
    output i_mode, i_frame_start, i_line_start, i_de, i_x, i_clr_underrun,
    input  o_pix, o_ready, o_underrun, o_gen
  );

  modport slave (
    input  i_mode, i_frame_start, i_line_start, i_de, i_x, i_clr_underrun,
    output o_pix, o_ready, o_underrun, o_gen
  );
endinterface

// File: rtl/ca_prng_line_gen.sv
// Multi-channel 1-D cellular-automaton line generator: the engine advances NUM_CH grids into a
// back buffer once per display line while the pixel path reads the front buffer.
module ca_prng_line_gen #(
  parameter int unsigned          NUM_CH         = 3,
  parameter int unsigned          CA_WIDTH       = 101,
  parameter logic [NUM_CH*8-1:0]  RULES          = {8'd150, 8'd60, 8'd30},
  parameter logic [CA_WIDTH-1:0]  SEED           = {50'd0, 1'b1, 50'd0},
  parameter int unsigned          GAP            = 20,
  parameter int unsigned          X_OFFSET       = 0,
  parameter int unsigned          STEPS_PER_LINE = 1,
  parameter int unsigned          XW             = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  ca_prng_line_gen_if.slave bus
);

  localparam int unsigned PITCH = CA_WIDTH + GAP;
  localparam int unsigned SPAN  = X_OFFSET + NUM_CH * PITCH - GAP;
  localparam int unsigned PW    = XW + 1;
  localparam int unsigned IDXW  = (CA_WIDTH > 1) ? $clog2(CA_WIDTH) : 1;
  localparam int unsigned CW    = (STEPS_PER_LINE > 1) ? $clog2(STEPS_PER_LINE) : 1;

  if (SPAN > (2 ** XW)) begin : g_bad_span
    $error("ca_prng_line_gen: channel segments extend past the 2**XW pixel range");
  end
  if (STEPS_PER_LINE == 0) begin : g_bad_steps
    $error("ca_prng_line_gen: STEPS_PER_LINE must be at least 1");
  end

  typedef logic [NUM_CH-1:0][CA_WIDTH-1:0] grid_t;
  typedef enum logic [1:0] {ST_READY, ST_STEP, ST_LOAD} state_t;

  localparam grid_t SEED_ALL = {NUM_CH{SEED}};

  state_t              state;
  grid_t               grid;
  grid_t               back;
  grid_t               front;
  grid_t               grid_nxt;
  logic [CW-1:0]       cnt;
  logic [CA_WIDTH-1:0] lft;
  logic [CA_WIDTH-1:0] rgt;
  logic [7:0]          rule;
  logic [PW-1:0]       xe;
  logic [PW-1:0]       x0;
  logic [IDXW-1:0]     idx;
  logic [7:0]          pix_c;

  // Next generation: rotated copies give every cell its wrapped left (i+1) and right (i-1) neighbour
  always_comb begin
    grid_nxt = '0;
    lft      = '0;
    rgt      = '0;
    rule     = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      lft  = {grid[c][0], grid[c][CA_WIDTH-1:1]};
      rgt  = {grid[c][CA_WIDTH-2:0], grid[c][CA_WIDTH-1]};
      rule = RULES[8*c +: 8];
      for (int i = 0; i < CA_WIDTH; i++) begin
        grid_nxt[c][i] = rule[{lft[i], grid[c][i], rgt[i]}];
      end
    end
  end

  // Line engine; a mode-0 frame start is applied last so it overrides the state's own action
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state          <= ST_READY;
      grid           <= SEED_ALL;
      back           <= SEED_ALL;
      front          <= '0;
      cnt            <= '0;
      bus.o_ready    <= 1'b1;
      bus.o_underrun <= 1'b0;
      bus.o_gen      <= '0;
    end else begin
      if (bus.i_line_start && (state != ST_READY)) begin
        bus.o_underrun <= 1'b1;
      end else if (bus.i_clr_underrun) begin
        bus.o_underrun <= 1'b0;
      end

      unique case (state)
        ST_READY: begin
          if (bus.i_line_start) begin
            front       <= back;
            cnt         <= '0;
            state       <= ST_STEP;
            bus.o_ready <= 1'b0;
          end
        end
        ST_STEP: begin
          grid      <= grid_nxt;
          bus.o_gen <= bus.o_gen + 16'd1;
          cnt       <= cnt + CW'(1);
          if (cnt == CW'(STEPS_PER_LINE - 1)) begin
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          back        <= grid;
          state       <= ST_READY;
          bus.o_ready <= 1'b1;
        end
        default: begin
          state       <= ST_READY;
          bus.o_ready <= 1'b1;
        end
      endcase

      if (bus.i_frame_start && !bus.i_mode) begin
        grid        <= SEED_ALL;
        bus.o_gen   <= '0;
        state       <= ST_LOAD;
        bus.o_ready <= 1'b0;
      end
    end
  end

  // Pixel lookup: find the channel segment covering i_x and colour set cells with channel+1
  always_comb begin
    pix_c = '0;
    xe    = PW'(bus.i_x);
    x0    = '0;
    idx   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      x0  = PW'(X_OFFSET + c * PITCH);
      idx = IDXW'(xe - x0);
      if (bus.i_de && (xe >= x0) && (xe < x0 + PW'(CA_WIDTH)) && front[c][idx]) begin
        pix_c = 8'(c + 1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      bus.o_pix <= '0;
    end else begin
      bus.o_pix <= pix_c;
    end
  end

endmodule

// File: tb/tb_ca_prng_line_gen.sv
// Directed bench for ca_prng_line_gen: a one-step-per-line instance and a four-step instance
// share clock and reset; expected pixels come from hand-evolved rule 30/60/150 patterns.
module tb_ca_prng_line_gen;
  localparam int unsigned XW = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  ca_prng_line_gen_if #(.XW(XW)) bus ();
  ca_prng_line_gen_if #(.XW(XW)) bus4 ();

  ca_prng_line_gen #(.XW(XW)) u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  ca_prng_line_gen #(.STEPS_PER_LINE(4), .XW(XW)) u_dut4 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus4.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic line(input bit a, input bit b);
    bus.i_line_start  = a;
    bus4.i_line_start = b;
    step();
    bus.i_line_start  = 1'b0;
    bus4.i_line_start = 1'b0;
  endtask

  task automatic pix(input bit sel4, input int x, input int exp, input string tag);
    if (sel4) begin
      bus4.i_de = 1'b1;
      bus4.i_x  = XW'(x);
    end else begin
      bus.i_de = 1'b1;
      bus.i_x  = XW'(x);
    end
    step();
    chk(tag, sel4 ? 32'(bus4.o_pix) : 32'(bus.o_pix), exp);
    bus.i_de  = 1'b0;
    bus4.i_de = 1'b0;
  endtask

  // Generation-1 picture from the single-cell seed at bit 50
  function automatic int gen1_pix(input int x);
    if (x >= 49 && x <= 51)   return 1;
    if (x == 170 || x == 171) return 2;
    if (x >= 291 && x <= 293) return 3;
    return 0;
  endfunction

  initial begin
    #200us;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.i_mode = 1'b0;  bus.i_frame_start = 1'b0;  bus.i_line_start = 1'b0;
    bus.i_de   = 1'b0;  bus.i_x = '0;              bus.i_clr_underrun = 1'b0;
    bus4.i_mode = 1'b0; bus4.i_frame_start = 1'b0; bus4.i_line_start = 1'b0;
    bus4.i_de   = 1'b0; bus4.i_x = '0;             bus4.i_clr_underrun = 1'b0;

    // Reset values
    step(2);
    chk("rst_ready",    32'(bus.o_ready), 1);
    chk("rst_pix",      32'(bus.o_pix), 0);
    chk("rst_underrun", 32'(bus.o_underrun), 0);
    chk("rst_gen",      32'(bus.o_gen), 0);
    chk("rst_ready4",   32'(bus4.o_ready), 1);
    rst = 1'b1;
    pix(0, 50, 0, "rst_front_blank");

    // Scenario 1: first line, then sweep the generation-1 picture
    line(1, 0);
    chk("s1_ready_drop", 32'(bus.o_ready), 0);
    step(2);
    chk("s1_ready_back", 32'(bus.o_ready), 1);
    chk("s1_gen1",       32'(bus.o_gen), 1);
    line(1, 0);
    bus.i_de = 1'b1;
    for (int x = 0; x < 640; x++) begin
      bus.i_x = XW'(x);
      step();
      chk($sformatf("sweep_x%0d", x), 32'(bus.o_pix), gen1_pix(x));
    end
    bus.i_de = 1'b0;

    // Scenario 2: display enable low and far-right column
    bus.i_x = XW'(50);
    step();
    chk("de_low", 32'(bus.o_pix), 0);
    pix(0, 1023, 0, "x_max");
    pix(0, 50, 1, "x50_gen1");

    // Scenario 4: ten lines, mode-0 reseed, then mode-1 free-run
    for (int l = 0; l < 10; l++) begin
      line(1, 0);
      step(2);
    end
    chk("gen_12", 32'(bus.o_gen), 12);
    bus.i_frame_start = 1'b1;
    step();
    bus.i_frame_start = 1'b0;
    chk("reseed_gen",   32'(bus.o_gen), 0);
    chk("reseed_ready", 32'(bus.o_ready), 0);
    step();
    chk("reseed_ready_back", 32'(bus.o_ready), 1);
    line(1, 0);
    pix(0, 50,  1, "seed_ch0");
    pix(0, 49,  0, "seed_ch0_left");
    pix(0, 171, 2, "seed_ch1");
    pix(0, 292, 3, "seed_ch2");
    bus.i_mode = 1'b1;
    bus.i_frame_start = 1'b1;
    step();
    bus.i_frame_start = 1'b0;
    chk("mode1_gen",   32'(bus.o_gen), 1);
    chk("mode1_ready", 32'(bus.o_ready), 1);
    line(1, 0);
    step(2);
    chk("mode1_gen_count", 32'(bus.o_gen), 2);
    pix(0, 49,  1, "scroll_ch0");
    pix(0, 170, 2, "scroll_ch1");

    // Scenario 5: simultaneous frame and line start while ready
    bus.i_mode = 1'b0;
    bus.i_frame_start = 1'b1;
    bus.i_line_start  = 1'b1;
    step();
    bus.i_frame_start = 1'b0;
    bus.i_line_start  = 1'b0;
    chk("both_gen",      32'(bus.o_gen), 0);
    chk("both_ready",    32'(bus.o_ready), 0);
    chk("both_underrun", 32'(bus.o_underrun), 0);
    step();
    chk("both_ready_back", 32'(bus.o_ready), 1);
    pix(0, 48,  1, "gen2_ch0_48");
    pix(0, 50,  0, "gen2_ch0_50");
    pix(0, 169, 2, "gen2_ch1_169");
    pix(0, 170, 0, "gen2_ch1_170");
    line(1, 0);
    pix(0, 50, 1, "both_seed_50");
    pix(0, 49, 0, "both_seed_49");

    // Scenario 3: underrun on the four-step instance
    line(0, 1);
    chk("s4_ready_drop", 32'(bus4.o_ready), 0);
    step();
    line(0, 1);
    chk("underrun_set", 32'(bus4.o_underrun), 1);
    step(2);
    chk("s4_ready_low", 32'(bus4.o_ready), 0);
    step();
    chk("s4_ready_5", 32'(bus4.o_ready), 1);
    chk("s4_gen4",    32'(bus4.o_gen), 4);
    pix(1, 50, 1, "s4_front_50");
    pix(1, 49, 0, "s4_front_49");
    chk("underrun_hold", 32'(bus4.o_underrun), 1);
    bus4.i_clr_underrun = 1'b1;
    step();
    bus4.i_clr_underrun = 1'b0;
    chk("underrun_clr", 32'(bus4.o_underrun), 0);
    line(0, 1);
    bus4.i_line_start   = 1'b1;
    bus4.i_clr_underrun = 1'b1;
    step();
    bus4.i_line_start   = 1'b0;
    bus4.i_clr_underrun = 1'b0;
    chk("underrun_set_wins", 32'(bus4.o_underrun), 1);
    bus4.i_clr_underrun = 1'b1;
    step();
    bus4.i_clr_underrun = 1'b0;
    chk("underrun_clr2", 32'(bus4.o_underrun), 0);
    step(5);

    // Scenario 5b: frame start aborts a step in progress
    line(0, 1);
    step();
    bus4.i_frame_start = 1'b1;
    step();
    bus4.i_frame_start = 1'b0;
    chk("abort_gen",   32'(bus4.o_gen), 0);
    chk("abort_ready", 32'(bus4.o_ready), 0);
    step();
    chk("abort_ready_back", 32'(bus4.o_ready), 1);
    chk("abort_gen_hold",   32'(bus4.o_gen), 0);
    line(0, 1);
    pix(1, 50, 1, "abort_seed_50");
    pix(1, 49, 0, "abort_seed_49");

    // Scenario 6: asynchronous reset in the middle of a step
    bus.i_de = 1'b1;
    bus.i_x  = XW'(50);
    line(1, 1);
    chk("pre_rst_pix",       32'(bus.o_pix), 1);
    chk("pre_rst_gen",       32'(bus.o_gen), 1);
    chk("pre_rst_ready",     32'(bus.o_ready), 0);
    chk("pre_rst_underrun4", 32'(bus4.o_underrun), 1);
    rst = 1'b0;
    #2;
    chk("arst_ready",     32'(bus.o_ready), 1);
    chk("arst_gen",       32'(bus.o_gen), 0);
    chk("arst_pix",       32'(bus.o_pix), 0);
    chk("arst_underrun4", 32'(bus4.o_underrun), 0);
    chk("arst_gen4",      32'(bus4.o_gen), 0);
    chk("arst_ready4",    32'(bus4.o_ready), 1);
    bus.i_de = 1'b0;
    step();
    rst = 1'b1;
    line(1, 0);
    step(2);
    chk("post_rst_ready", 32'(bus.o_ready), 1);
    chk("post_rst_gen",   32'(bus.o_gen), 1);
    line(1, 0);
    pix(0, 48,  0, "post_rst_48");
    pix(0, 49,  1, "post_rst_49");
    pix(0, 51,  1, "post_rst_51");
    pix(0, 52,  0, "post_rst_52");
    pix(0, 171, 2, "post_rst_171");
    pix(0, 172, 0, "post_rst_172");
    pix(0, 293, 3, "post_rst_293");
    pix(0, 294, 0, "post_rst_294");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
